// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: widths, FSM states and ALU opcodes shared by the arbiter and its ALU.
package alu_arbiter_pkg;
    localparam int XLEN    = 32;
    localparam int CTRL_W  = 4;
    localparam int SHAMT_W = $clog2(XLEN);
    localparam logic [CTRL_W-1:0] MAX_CTRL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [CTRL_W-1:0] OP_ADD = 4'd0;
    localparam logic [CTRL_W-1:0] OP_SUB = 4'd1;
    localparam logic [CTRL_W-1:0] OP_AND = 4'd2;
    localparam logic [CTRL_W-1:0] OP_OR  = 4'd3;
    localparam logic [CTRL_W-1:0] OP_XOR = 4'd4;
    localparam logic [CTRL_W-1:0] OP_SLL = 4'd5;
    localparam logic [CTRL_W-1:0] OP_SRL = 4'd6;
    localparam logic [CTRL_W-1:0] OP_SRA = 4'd7;
    localparam logic [CTRL_W-1:0] OP_SLT = 4'd8;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: single-cycle combinational ALU; zero flag follows the result.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [XLEN-1:0]   y_o,
    output logic              zero_o
);
    logic [SHAMT_W-1:0] shamt;

    assign shamt  = b_i[SHAMT_W-1:0];
    assign zero_o = y_o == '0;

    always_comb begin
        y_o = '0;
        case (ctrl_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLL:  y_o = a_i << shamt;
            OP_SRL:  y_o = a_i >> shamt;
            OP_SRA:  y_o = $signed(a_i) >>> shamt;
            OP_SLT:  y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters, one transaction in flight.
// Define ALU_ARB_FIXED_PRIO_EN to give port 0 absolute priority instead of round-robin.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [XLEN-1:0]   req0_in1,
    input  logic [XLEN-1:0]   req0_in2,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [XLEN-1:0]   resp0_result,
    output logic              resp0_zero,
    output logic              resp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [XLEN-1:0]   req1_in1,
    input  logic [XLEN-1:0]   req1_in2,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [XLEN-1:0]   resp1_result,
    output logic              resp1_zero,
    output logic              resp1_err
);
    state_e            state_q, state_d;
    logic              owner_q, pick1, accept, resp_accept, illegal, alu_zero;
    logic              zero_q, err_q;
    logic [XLEN-1:0]   in1_q, in2_q, result_q, alu_y;
    logic [CTRL_W-1:0] ctrl_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign pick1 = !req0_valid;
`else
    logic last_grant_q;
    // On contention the port that did not win last time goes first.
    assign pick1 = req1_valid && !(req0_valid && last_grant_q);
    always_ff @(posedge clk) begin
        if (rst)
            last_grant_q <= 1'b1;
        else if (accept)
            last_grant_q <= pick1;
    end
`endif

    assign accept      = state_q == IDLE && (req0_valid || req1_valid);
    assign req0_ready  = accept && !pick1;
    assign req1_ready  = accept && pick1;
    assign resp0_valid = state_q == RESP && !owner_q;
    assign resp1_valid = state_q == RESP && owner_q;
    assign resp_accept = owner_q ? resp1_ready : resp0_ready;
    assign illegal     = ctrl_q > MAX_CTRL;

    assign resp0_result = result_q;
    assign resp1_result = result_q;
    assign resp0_zero   = zero_q;
    assign resp1_zero   = zero_q;
    assign resp0_err    = err_q;
    assign resp1_err    = err_q;

    alu_arbiter_alu u_alu (
        .a_i   (in1_q),
        .b_i   (in2_q),
        .ctrl_i(ctrl_q),
        .y_o   (alu_y),
        .zero_o(alu_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = resp_accept ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept)
                owner_q <= pick1;
            if (state_q == EXEC) begin
                result_q <= illegal ? '0 : alu_y;
                zero_q   <= !illegal && alu_zero;
                err_q    <= illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            in1_q  <= pick1 ? req1_in1 : req0_in1;
            in2_q  <= pick1 ? req1_in2 : req0_in2;
            ctrl_q <= pick1 ? req1_ctrl : req0_ctrl;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench; expected responses are queued at acceptance.
module tb_alu_arbiter;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        v[2], rdy[2], rv[2], rr[2], z[2], e[2], hold[2];
    logic [31:0] i1[2], i2[2], res[2];
    logic [3:0]  c[2];
    logic        rand_rr;

    logic [33:0] q[2][$];
    int          glog[$];
    int          vectors = 0, miscompares = 0;
    int          last = 1, since = 99, own = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_in1(i1[0]), .req0_in2(i2[0]), .req0_ctrl(c[0]),
        .resp0_valid(rv[0]), .resp0_ready(rr[0]), .resp0_result(res[0]), .resp0_zero(z[0]), .resp0_err(e[0]),
        .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_in1(i1[1]), .req1_in2(i2[1]), .req1_ctrl(c[1]),
        .resp1_valid(rv[1]), .resp1_ready(rr[1]), .resp1_result(res[1]), .resp1_zero(z[1]), .resp1_err(e[1])
    );

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r;
        if (op > 4'd8) return {1'b1, 1'b0, 32'd0};
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            4'd6:    r = a >> b[4:0];
            4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        return {1'b0, r == 32'd0, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer side: ready is random, forced high, or held low per port.
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < 2; p++)
            rr[p] = hold[p] ? 1'b0 : (rand_rr ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Monitor: scoreboard push at acceptance, pop/compare on presented responses.
    always @(negedge clk) begin
        if (rst) begin
            q[0].delete();
            q[1].delete();
            last  = 1;
            since = 99;
        end else begin
            check("ready_exclusive", {63'd0, rdy[0] && rdy[1]}, 64'd0);
            check("resp_exclusive", {63'd0, rv[0] && rv[1]}, 64'd0);
            if (rdy[0] || rdy[1]) begin
                int w;
                w = rdy[1] ? 1 : 0;
                check("ready_needs_valid", {63'd0, v[w]}, 64'd1);
                if (v[0] && v[1])
                    check("arb_winner", 64'(w), FIXED ? 64'd0 : (last == 1 ? 64'd0 : 64'd1));
                last  = w;
                own   = w;
                since = 0;
                glog.push_back(w);
                q[w].push_back(model(i1[w], i2[w], c[w]));
            end else begin
                since++;
            end
            if (since == 1)
                check("exec_quiet", {60'd0, rv[0], rv[1], rdy[0], rdy[1]}, 64'd0);
            if (since == 2)
                check("resp_latency", {63'd0, rv[own]}, 64'd1);
            for (int p = 0; p < 2; p++) begin
                if (rv[p]) begin
                    if (q[p].size() == 0)
                        check(p == 0 ? "spurious_resp0" : "spurious_resp1", {63'd0, rv[p]}, 64'd0);
                    else begin
                        check(p == 0 ? "resp0_data" : "resp1_data", {30'd0, e[p], z[p], res[p]}, {30'd0, q[p][0]});
                        if (rr[p]) void'(q[p].pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, output int waited);
        waited = 0;
        v[p] = 1'b1; i1[p] = a; i2[p] = b; c[p] = op;
        do begin
            @(negedge clk);
            waited++;
        end while (!rdy[p] && waited < 200);
        if (!rdy[p]) check("ready_timeout", {63'd0, rdy[p]}, 64'd1);
        @(posedge clk);
        #1;
        v[p] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(q[0].size() + q[1].size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_op(input int p);
        int          t;
        logic [31:0] a, b;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        if ($urandom_range(0, 7) == 0) begin
            v[p] = 1'b1; i1[p] = a; i2[p] = b; c[p] = 4'($urandom_range(0, 15));
            @(negedge clk);
            @(posedge clk);
            #1;
            v[p] = 1'b0;
        end else
            issue(p, a, b, 4'($urandom_range(0, 15)), t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1; rand_rr = 1'b0;
        for (int p = 0; p < 2; p++) begin
            v[p] = 1'b0; i1[p] = '0; i2[p] = '0; c[p] = '0; hold[p] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_resp_valid", {62'd0, rv[0], rv[1]}, 64'd0);
        check("reset_result", {res[0], res[1]}, 64'd0);
        check("reset_flags", {60'd0, z[0], e[0], z[1], e[1]}, 64'd0);
        @(posedge clk);
        #1;

        issue(0, 32'd5, 32'd6, 4'b0000, t);
        check("port0_ready_immediate", 64'(t), 64'd1);
        drain();

        // Response held unaccepted: fields stay put and port 1 is locked out.
        hold[0] = 1'b1;
        issue(0, 32'd7, 32'd7, 4'b0001, t);
        v[1] = 1'b1; i1[1] = 32'd9; i2[1] = 32'd3; c[1] = 4'b0010;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("held_resp0_valid", {63'd0, rv[0]}, 64'd1);
            check("held_req1_ready", {63'd0, rdy[1]}, 64'd0);
        end
        hold[0] = 1'b0;
        @(posedge clk);
        #1;
        issue(1, 32'd9, 32'd3, 4'b0010, t);
        drain();

        issue(1, 32'd5, 32'd6, 4'b1001, t);
        issue(1, 32'd5, 32'd6, 4'b0000, t);
        drain();

        // Reset while the ALU stage is busy: nothing must come out.
        issue(0, 32'd1, 32'd2, 4'b0000, t);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valids", {60'd0, rv[0], rv[1], rdy[0], rdy[1]}, 64'd0);
        check("midrst_result", {res[0], res[1]}, 64'd0);
        check("midrst_flags", {60'd0, z[0], e[0], z[1], e[1]}, 64'd0);
        repeat (3) @(posedge clk);
        #1;

        glog.delete();
        fork
            for (int k = 0; k < 4; k++) begin int t0; issue(0, 32'd10 + k, 32'd3, 4'b0001, t0); end
            for (int k = 0; k < 4; k++) begin int t1; issue(1, 32'd20 + k, 32'd4, 4'b0001, t1); end
        join
        drain();
        check("grant_order_len", 64'(glog.size()), 64'd8);
        if (glog.size() >= 4)
            check("grant_order", {glog[0][15:0], glog[1][15:0], glog[2][15:0], glog[3][15:0]},
                  FIXED ? 64'h0000_0000_0000_0000 : 64'h0000_0001_0000_0001);

        for (int op = 0; op <= 8; op++)
            issue(op % 2, 32'd5, 32'd6, 4'(op), t);
        drain();

        rand_rr = 1'b1;
        fork
            for (int k = 0; k < 40; k++) rnd_op(0);
            for (int k = 0; k < 40; k++) rnd_op(1);
        join
        rand_rr = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
